hough_vote_sched: RTL

Per-frame controller between the left/right feature-point extractors and the single shared Hough voting engine. It buffers left-region and right-region feature points in two small FIFOs and arbitrates them round-robin onto one valid/ready vote port. It also sequences the engine through each frame: clear the accumulator, collect votes, drain, then trigger the peak search.

---
 rtl/hough_pkg.sv | 19 +
 rtl/point_fifo.sv | 64 ++++++
 rtl/hough_vote_sched.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/hough_pkg.sv
// Shared definitions for the Hough voting pipeline: frame-controller states,
// side encoding and coordinate widths used by the engine and the peak search.
package hough_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned POINT_W = 2 * COORD_W;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StCollect,
    StDrain,
    StSearch
  } state_e;

endpackage

// File: rtl/point_fifo.sv
// Show-ahead synchronous FIFO for packed {x, y} feature points. Full/empty are
// registered; a write into a full FIFO is accepted when a read happens in the same cycle.
module point_fifo
  import hough_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en_i,
  input  logic [POINT_W-1:0] wr_data_i,
  input  logic               rd_en_i,
  output logic [POINT_W-1:0] rd_data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AddrW-1:0] PtrOne = AddrW'(1);
  localparam logic [AddrW:0] CntFull = (AddrW + 1)'(DEPTH);

  logic [POINT_W-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]   wptr_q, rptr_q;
  logic [AddrW:0]     cnt_q, cnt_d;
  logic               full_q, empty_q;
  logic               push, pop;

  always_comb begin
    pop   = rd_en_i && !empty_q;
    push  = wr_en_i && (!full_q || pop);
    cnt_d = cnt_q + {{AddrW{1'b0}}, push} - {{AddrW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrOne;
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrOne;
      end
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CntFull);
      empty_q <= (cnt_d == '0);
    end
  end

  assign rd_data_o = mem_q[rptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/hough_vote_sched.sv
// Per-frame controller for the shared Hough voting engine: buffers left/right feature
// points, arbitrates them round-robin onto one vote port and sequences clear/vote/search.
module hough_vote_sched
  import hough_pkg::*;
#(
  parameter int unsigned H_DISP     = 640,
  parameter int unsigned V_DISP     = 480,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start_i,
  input  logic               frame_end_i,
  input  logic               left_de_i,
  input  logic [COORD_W-1:0] x_left_i,
  input  logic [COORD_W-1:0] y_left_i,
  input  logic               right_de_i,
  input  logic [COORD_W-1:0] x_right_i,
  input  logic [COORD_W-1:0] y_right_i,
  output logic               vote_valid_o,
  input  logic               vote_ready_i,
  output logic [COORD_W-1:0] vote_x_o,
  output logic [COORD_W-1:0] vote_y_o,
  output logic               vote_side_o,
  output logic               acc_clr_o,
  input  logic               acc_clr_done_i,
  output logic               peak_start_o,
  input  logic               peak_done_i,
  output logic               busy_o,
  output logic [CNT_W-1:0]   vote_cnt_o,
  output logic [CNT_W-1:0]   drop_cnt_o
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (H_DISP > (1 << COORD_W) || V_DISP > (1 << COORD_W)) begin : gen_bad_disp
    $error("image size does not fit the coordinate width");
  end

  state_e state_q;
  logic   end_pend_q, acc_clr_q, peak_start_q, busy_q;

  logic               l_full, l_empty, r_full, r_empty;
  logic               l_wr, r_wr, l_rd, r_rd;
  logic [POINT_W-1:0] l_data, r_data;

  logic               vld_q, vld_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               side_q, side_d, last_q, last_d;

  logic [CNT_W-1:0] vote_cnt_q, vote_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [CNT_W:0]   vote_sum, drop_sum;

  logic collect, out_free, hs, drained, frame_go;
  logic drop_l, drop_r;

  always_comb begin
    collect  = (state_q == StCollect);
    frame_go = (state_q == StIdle) && frame_start_i;
    out_free = !vld_q || vote_ready_i;
    hs       = vld_q && vote_ready_i;
    // Right wins when it is the only candidate or when left was granted last.
    r_rd     = out_free && !r_empty && (l_empty || (last_q == SIDE_LEFT));
    l_rd     = out_free && !l_empty && !r_rd;
    l_wr     = collect && left_de_i;
    r_wr     = collect && right_de_i;
    drop_l   = l_wr && l_full && !l_rd;
    drop_r   = r_wr && r_full && !r_rd;
    drained  = l_empty && r_empty && out_free;
  end

  point_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo_left (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (l_wr),
    .wr_data_i({x_left_i, y_left_i}),
    .rd_en_i  (l_rd),
    .rd_data_o(l_data),
    .full_o   (l_full),
    .empty_o  (l_empty)
  );

  point_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo_right (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (r_wr),
    .wr_data_i({x_right_i, y_right_i}),
    .rd_en_i  (r_rd),
    .rd_data_o(r_data),
    .full_o   (r_full),
    .empty_o  (r_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      end_pend_q   <= 1'b0;
      acc_clr_q    <= 1'b0;
      peak_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      peak_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_start_i) begin
            state_q    <= StClear;
            acc_clr_q  <= 1'b1;
            busy_q     <= 1'b1;
            end_pend_q <= 1'b0;
          end
        end
        StClear: begin
          if (frame_end_i) begin
            end_pend_q <= 1'b1;
          end
          if (acc_clr_done_i) begin
            state_q   <= StCollect;
            acc_clr_q <= 1'b0;
          end
        end
        StCollect: begin
          if (frame_end_i || end_pend_q) begin
            state_q    <= StDrain;
            end_pend_q <= 1'b0;
          end
        end
        StDrain: begin
          if (drained) begin
            state_q      <= StSearch;
            peak_start_q <= 1'b1;
          end
        end
        StSearch: begin
          if (peak_done_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    vld_d  = vld_q;
    x_d    = x_q;
    y_d    = y_q;
    side_d = side_q;
    last_d = last_q;
    if (l_rd) begin
      vld_d      = 1'b1;
      {x_d, y_d} = l_data;
      side_d     = SIDE_LEFT;
      last_d     = SIDE_LEFT;
    end else if (r_rd) begin
      vld_d      = 1'b1;
      {x_d, y_d} = r_data;
      side_d     = SIDE_RIGHT;
      last_d     = SIDE_RIGHT;
    end else if (hs) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      side_q <= SIDE_LEFT;
      last_q <= SIDE_RIGHT;
    end else begin
      vld_q  <= vld_d;
      x_q    <= x_d;
      y_q    <= y_d;
      side_q <= side_d;
      last_q <= last_d;
    end
  end

  // Handshakes only occur while collecting or draining, so the vote count is final
  // once the frame reaches the peak search and stays readable until the next frame.
  always_comb begin
    vote_sum   = {1'b0, vote_cnt_q} + {{CNT_W{1'b0}}, hs};
    drop_sum   = {1'b0, drop_cnt_q} + {{CNT_W{1'b0}}, drop_l} + {{CNT_W{1'b0}}, drop_r};
    vote_cnt_d = vote_sum[CNT_W] ? {CNT_W{1'b1}} : vote_sum[CNT_W-1:0];
    drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    if (frame_go) begin
      vote_cnt_d = '0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      vote_cnt_q <= vote_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign vote_valid_o = vld_q;
  assign vote_x_o     = x_q;
  assign vote_y_o     = y_q;
  assign vote_side_o  = side_q;
  assign acc_clr_o    = acc_clr_q;
  assign peak_start_o = peak_start_q;
  assign busy_o       = busy_q;
  assign vote_cnt_o   = vote_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule
